serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 91 +++++++++
 tb/tb_serial_addsub.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master drives a request; the slave returns status and the held result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Subtraction loads ~b and a carry-in of 1; flags are valid with the done pulse.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             carry_q;
    logic             ovf_q;

    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] sr_d;
    logic             last_bit;
    logic             accept;

    assign sum_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
    assign carry_d  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    assign sr_d     = {sum_bit, sr_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // A new request is taken in IDLE and also in DONE, giving back-to-back operation.
    assign accept   = bus.start && (state_q != RUN);

    // NOTE: every datapath register is reset, not just the state, so an aborted
    // operation leaves no stale operand bits and the held outputs read 0 after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.mode ? ~bus.b : bus.b;
                        c_q     <= bus.mode;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sr_q  <= sr_d;
                    c_q   <= carry_d;
                    cnt_q <= cnt_q + CW'(1);
                    // On the MSB bit, c_q is the carry into the MSB and carry_d the carry out.
                    if (last_bit) begin
                        result_q <= sr_d;
                        carry_q  <= carry_d;
                        ovf_q    <= c_q ^ carry_d;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: arithmetic-level model checked every cycle on a
// WIDTH=8 and a WIDTH=4 instance, plus hand-computed directed vectors.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_done4 = 0;

    serial_addsub_if #(.WIDTH(8)) if8 ();
    serial_addsub_if #(.WIDTH(4)) if4 ();

    serial_addsub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
    serial_addsub #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int run;
        bit done;
        int res;
        bit c;
        bit v;
        int pr;
        bit pc;
        bit pv;
    } mdl_t;

    mdl_t m8;
    mdl_t m4;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain modular arithmetic: unsigned carry/no-borrow and signed overflow.
    function automatic void calc(input int w, input int a, input int b, input bit m,
                                 output int r, output bit c, output bit v);
        int mask = (1 << w) - 1;
        bit sa, sb, sr;
        if (!m) begin
            r = (a + b) & mask;
            c = ((a + b) >> w) != 0;
        end else begin
            r = (a - b) & mask;
            c = (a >= b);
        end
        sa = ((a >> (w - 1)) & 1) != 0;
        sb = ((b >> (w - 1)) & 1) != 0;
        sr = ((r >> (w - 1)) & 1) != 0;
        v  = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    task automatic step(inout mdl_t m, input int w, input bit st,
                        input int a, input int b, input bit md);
        if (m.run > 0) begin
            m.run--;
            if (m.run == 0) begin
                m.done = 1'b1;
                m.res  = m.pr;
                m.c    = m.pc;
                m.v    = m.pv;
            end
        end else begin
            m.done = 1'b0;
            if (st) begin
                calc(w, a, b, md, m.pr, m.pc, m.pv);
                m.run = w;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m8 = '{default: 0};
        else step(m8, 8, if8.start, int'(if8.a), int'(if8.b), if8.mode);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) m4 = '{default: 0};
        else step(m4, 4, if4.start, int'(if4.a), int'(if4.b), if4.mode);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8",   if8.busy,      m8.run > 0);
            check("done8",   if8.done,      m8.done);
            check("result8", if8.result,    m8.res);
            check("cout8",   if8.carry_out, m8.c);
            check("ovf8",    if8.overflow,  m8.v);
            check("busy4",   if4.busy,      m4.run > 0);
            check("done4",   if4.done,      m4.done);
            check("result4", if4.result,    m4.res);
            check("cout4",   if4.carry_out, m4.c);
            check("ovf4",    if4.overflow,  m4.v);
            if (if4.done) n_done4++;
        end
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic m);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.mode  = m;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    // Entered one negedge after the accepting edge; lat counts cycles since that edge.
    task automatic wait_done8(output int lat, output int busy_cyc);
        lat = 1;
        busy_cyc = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!if8.done) check("timeout8", if8.done, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [7:0] er, input logic ec, input logic ev, input string nm);
        int lat, bc;
        start8(a, b, m);
        wait_done8(lat, bc);
        check({nm, "_latency"}, lat, 9);
        check({nm, "_busy"},    bc, 8);
        check({nm, "_result"},  if8.result, er);
        check({nm, "_cout"},    if8.carry_out, ec);
        check({nm, "_ovf"},     if8.overflow, ev);
    endtask

    task automatic count_done8(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if8.done) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bc, extra, t1;
        rst = 1'b1;
        if8.start = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.mode = 1'b0; if4.a = '0; if4.b = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   if8.busy, 0);
        check("rst_done",   if8.done, 0);
        check("rst_result", if8.result, 0);

        op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, "add_3c_05");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        op8(8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, "sub_10_10");

        // Start pulse with different operands while busy must be dropped.
        start8(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h00;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8(lat, bc);
        check("ign_result", if8.result, 8'h30);
        count_done8(12, extra);
        check("ign_single_done", extra, 0);

        // Start held through DONE: second op accepted with no IDLE cycle.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.mode = 1'b0;
        @(negedge clk);
        if8.a = 8'h80; if8.b = 8'h01; if8.mode = 1'b1;
        wait_done8(lat, bc);
        t1 = cyc;
        check("b2b_first_result", if8.result, 8'h46);
        @(negedge clk);
        if8.start = 1'b0;
        check("b2b_no_idle", if8.busy, 1);
        wait_done8(lat, bc);
        check("b2b_gap", cyc - t1, 9);
        check("b2b_second_result", if8.result, 8'h7F);
        check("b2b_second_cout",   if8.carry_out, 1);
        check("b2b_second_ovf",    if8.overflow, 1);

        // Asynchronous reset between edges with the bit counter at 3.
        start8(8'h3C, 8'h05, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   if8.busy, 0);
        check("arst_done",   if8.done, 0);
        check("arst_result", if8.result, 0);
        check("arst_cout",   if8.carry_out, 0);
        check("arst_ovf",    if8.overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        count_done8(12, extra);
        check("arst_no_done", extra, 0);
        op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, "post_rst_add");

        // WIDTH=4 exhaustive, back-to-back, checked by the per-cycle model.
        n_done4 = 0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int m = 0; m < 2; m++) begin
                    if4.a = 4'(a); if4.b = 4'(b); if4.mode = m[0]; if4.start = 1'b1;
                    @(negedge clk);
                    lat = 0;
                    while (!if4.done && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    if (!if4.done) check("timeout4", if4.done, 1);
                end
            end
        end
        if4.start = 1'b0;
        repeat (3) @(negedge clk);
        check("w4_done_count", n_done4, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
